// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
//   INST_W / ADDR_W : instruction and word-address widths
//   DEF_RESET_PC    : default first fetch address
//   ifq_entry_t     : prefetch FIFO entry {pc, inst}
package ifq_pkg;

   localparam int INST_W = 16;
   localparam int ADDR_W = 16;

   localparam logic [ADDR_W-1:0] DEF_RESET_PC = 16'h0000;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Prefetch FIFO for the instruction fetch queue.
// DEPTH entries (power of 2), pointers wrap through the natural index width.
// Ports:
//   clk, rst          clock, async active-high reset
//   i_push / i_data   write an entry (ignored on flush)
//   i_pop             remove head (ignored when empty or on flush)
//   i_flush           empty the FIFO; has priority over push/pop
//   o_head            current head; holds the last head while empty
//   o_count           number of valid entries
//   o_full / o_empty  status flags
module ifq_fifo
   import ifq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  ifq_entry_t             i_data,
   input  logic                   i_pop,
   input  logic                   i_flush,
   output ifq_entry_t             o_head,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_full,
   output logic                   o_empty
);

   localparam int PW = $clog2(DEPTH);

   ifq_entry_t    r_mem [DEPTH];
   ifq_entry_t    r_last;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW:0]   r_count;

   logic w_do_push;
   logic w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == (PW+1)'(DEPTH));
   assign o_count   = r_count;
   assign w_do_push = i_push && !i_flush;
   assign w_do_pop  = i_pop && !o_empty && !i_flush;

   // Stale array contents must never leak out once the FIFO drains,
   // so an empty FIFO presents the last head it actually had.
   assign o_head = o_empty ? r_last : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_last   <= '0;
      end else begin
         if (!o_empty) begin
            r_last <= r_mem[r_rd_ptr];
         end
         if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_do_push, w_do_pop})
               2'b10:   r_count <= r_count + (PW+1)'(1);
               2'b01:   r_count <= r_count - (PW+1)'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: sequential word-address generation, credit-based
// request issue to instruction memory, in-order response buffering and
// branch-redirect flush with discard of in-flight responses.
// Ports:
//   clk, rst                          clock, async active-high reset
//   imem_req_valid/ready, imem_addr   fetch request channel
//   imem_rsp_valid, imem_rsp_data     in-order response channel (no backpressure)
//   redir_valid, redir_pc             branch redirect
//   inst_valid/ready, inst_data/pc    instruction to decode
// Build option: IFQ_BYPASS_EN routes a response straight to inst_* when the
// FIFO is empty (zero-cycle latency); undefined, inst_* come only from the FIFO.
module instr_fetch_queue
   import ifq_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rsp_valid,
   input  logic [INST_W-1:0] imem_rsp_data,
   input  logic              redir_valid,
   input  logic [ADDR_W-1:0] redir_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

   logic [ADDR_W-1:0] r_fetch_pc;
   logic [ADDR_W-1:0] r_rsp_pc;
   logic [CW-1:0]     r_outstanding;
   logic [CW-1:0]     r_drop_cnt;

   logic              w_accept;
   logic              w_keep;
   logic              w_push;
   logic              w_pop;
   logic [CW:0]       w_in_use;
   logic [CW-1:0]     w_fifo_count;
   logic              w_fifo_full;
   logic              w_fifo_empty;
   ifq_entry_t        w_fifo_head;
   ifq_entry_t        w_rsp_entry;

   // Every issued request already owns a FIFO slot, which is why the
   // response channel never needs backpressure.
   assign w_in_use       = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
   assign imem_req_valid = !rst && !redir_valid && (w_in_use < LIMIT);
   assign imem_addr      = r_fetch_pc;
   assign w_accept       = imem_req_valid && imem_req_ready;

   assign w_keep      = imem_rsp_valid && (r_drop_cnt == '0) && !redir_valid;
   assign w_rsp_entry = '{pc: r_rsp_pc, inst: imem_rsp_data};
   assign w_pop       = inst_ready && !w_fifo_empty;

`ifdef IFQ_BYPASS_EN
   logic w_bypass;
   assign w_bypass   = w_keep && w_fifo_empty;
   assign inst_valid = !w_fifo_empty || w_bypass;
   assign inst_data  = w_bypass ? imem_rsp_data : w_fifo_head.inst;
   assign inst_pc    = w_bypass ? r_rsp_pc      : w_fifo_head.pc;
   assign w_push     = w_keep && !w_fifo_full && !(w_bypass && inst_ready);
`else
   assign inst_valid = !w_fifo_empty;
   assign inst_data  = w_fifo_head.inst;
   assign inst_pc    = w_fifo_head.pc;
   assign w_push     = w_keep && !w_fifo_full;
`endif

   ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_rsp_entry),
      .i_pop   (w_pop),
      .i_flush (redir_valid),
      .o_head  (w_fifo_head),
      .o_count (w_fifo_count),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc    <= RESET_PC;
         r_rsp_pc      <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else begin
         case ({w_accept, imem_rsp_valid})
            2'b10:   r_outstanding <= r_outstanding + CW'(1);
            2'b01:   r_outstanding <= r_outstanding - CW'(1);
            default: r_outstanding <= r_outstanding;
         endcase

         if (redir_valid) begin
            r_fetch_pc <= redir_pc;
            r_rsp_pc   <= redir_pc;
            // No request is accepted this cycle, so what remains in flight
            // after the edge is outstanding less any response arriving now.
            r_drop_cnt <= r_outstanding - CW'(imem_rsp_valid);
         end else begin
            if (w_accept) r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
            if (w_keep)   r_rsp_pc   <= r_rsp_pc + ADDR_W'(1);
            if (imem_rsp_valid && (r_drop_cnt != '0)) begin
               r_drop_cnt <= r_drop_cnt - CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue (DEPTH=4, RESET_PC=16'hFFFE).
// Memory returns word (addr ^ 16'h5A5A) after a programmable latency.
module tb_instr_fetch_queue;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [15:0] imem_addr;
   logic        imem_rsp_valid;
   logic [15:0] imem_rsp_data;
   logic        redir_valid;
   logic [15:0] redir_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [15:0] inst_data;
   logic [15:0] inst_pc;

   int n_cmp   = 0;
   int n_bad   = 0;
   int cyc     = 0;
   int mem_lat = 1;
   int acc_cnt = 0;

   logic [15:0] q_addr[$];
   int          q_due[$];
   logic [15:0] pop_pc[$];
   logic [15:0] pop_data[$];
   int          pop_cyc[$];

   instr_fetch_queue #(.DEPTH(4), .RESET_PC(16'hFFFE)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redir_valid    (redir_valid),
      .redir_pc       (redir_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return a ^ 16'h5A5A;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
      #1;
   endtask

   // memory response side: in order, one per cycle, after mem_lat cycles
   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 16'h0000;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (rst) begin
            q_addr.delete();
            q_due.delete();
            imem_rsp_valid = 1'b0;
         end else if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
         end
      end
   end

   // request capture and instruction-consumption log
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (imem_req_valid && imem_req_ready) begin
               acc_cnt++;
               q_addr.push_back(imem_addr);
               q_due.push_back(cyc + mem_lat);
            end
            if (inst_valid && inst_ready) begin
               pop_pc.push_back(inst_pc);
               pop_data.push_back(inst_data);
               pop_cyc.push_back(cyc);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_pops();
      pop_pc.delete();
      pop_data.delete();
      pop_cyc.delete();
   endtask

   task automatic start_run(input logic rdy, input int lat);
      rst            = 1'b1;
      redir_valid    = 1'b0;
      redir_pc       = 16'h0000;
      imem_req_ready = 1'b1;
      inst_ready     = rdy;
      mem_lat        = lat;
      repeat (2) tick();
      clear_pops();
      acc_cnt = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_pops(input string tag, input int n);
      int b;
      b = 0;
      while (pop_pc.size() < n && b < 60) begin
         samp();
         b++;
      end
      chk(tag, (pop_pc.size() >= n) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic chk_pop(input string tag, input int i, input logic [15:0] pc);
      logic [15:0] p;
      logic [15:0] d;
      p = 'x;
      d = 'x;
      if (i < pop_pc.size()) begin
         p = pop_pc[i];
         d = pop_data[i];
      end
      chk({tag, "_pc"}, {16'h0, p}, {16'h0, pc});
      chk({tag, "_data"}, {16'h0, d}, {16'h0, mem_word(pc)});
   endtask

   initial begin
      int rc;
      int vc;
      int n;
      logic [15:0] exp_pc;

      rst            = 1'b1;
      redir_valid    = 1'b0;
      redir_pc       = 16'h0000;
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;

      // reset values
      samp();
      chk("rst_req_valid", {31'h0, imem_req_valid}, 32'd0);
      chk("rst_addr",      {16'h0, imem_addr},      32'hFFFE);
      chk("rst_inst_valid",{31'h0, inst_valid},     32'd0);
      chk("rst_inst_data", {16'h0, inst_data},      32'd0);
      chk("rst_inst_pc",   {16'h0, inst_pc},        32'd0);

      // streaming with 1-cycle memory, downstream always ready, pc wrap
      start_run(1'b1, 1);
      samp();
      chk("t1_first_req",  {31'h0, imem_req_valid}, 32'd1);
      chk("t1_first_addr", {16'h0, imem_addr},      32'hFFFE);
      rc = -1;
      vc = -1;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) samp();
         if (rc < 0 && imem_rsp_valid) rc = i;
         if (vc < 0 && inst_valid)     vc = i;
      end
      chk("t1_rsp_lat", rc, 32'd1);
`ifdef IFQ_BYPASS_EN
      chk("t1_inst_lat", vc - rc, 32'd0);
`else
      chk("t1_inst_lat", vc - rc, 32'd1);
`endif
      wait_pops("t1_fill", 6);
      exp_pc = 16'hFFFE;
      for (int i = 0; i < 6; i++) begin
         chk_pop("t1_seq", i, exp_pc);
         exp_pc = exp_pc + 16'd1;
      end
      chk("t1_rate", (pop_cyc.size() >= 6) ? (pop_cyc[5] - pop_cyc[0]) : -1, 32'd5);

      // downstream stalled: credit limits to DEPTH requests, then drains in order
      start_run(1'b0, 1);
      repeat (10) samp();
      chk("t2_accepts",   acc_cnt,                  32'd4);
      chk("t2_req_low",   {31'h0, imem_req_valid},  32'd0);
      tick();
      clear_pops();
      inst_ready = 1'b1;
      wait_pops("t2_drain", 5);
      exp_pc = 16'hFFFE;
      for (int i = 0; i < 5; i++) begin
         chk_pop("t2_seq", i, exp_pc);
         exp_pc = exp_pc + 16'd1;
      end

      // redirect with three requests in flight
      start_run(1'b1, 6);
      tick();
      tick();
      tick();
      imem_req_ready = 1'b0;
      redir_valid    = 1'b1;
      redir_pc       = 16'h0040;
      mem_lat        = 1;
      samp();
      chk("t3_in_flight", acc_cnt, 32'd3);
      chk("t3_no_req_redir", {31'h0, imem_req_valid}, 32'd0);
      tick();
      redir_valid    = 1'b0;
      imem_req_ready = 1'b1;
      clear_pops();
      samp();
      chk("t3_empty",     {31'h0, inst_valid},     32'd0);
      chk("t3_req_valid", {31'h0, imem_req_valid}, 32'd1);
      chk("t3_req_addr",  {16'h0, imem_addr},      32'h0040);
      wait_pops("t3_refill", 2);
      chk_pop("t3_first", 0, 16'h0040);
      chk_pop("t3_second", 1, 16'h0041);

      // redirect coincident with a response and a pop
      start_run(1'b1, 1);
      repeat (12) tick();
      redir_valid = 1'b1;
      redir_pc    = 16'h0100;
      samp();
      chk("t4_rsp_coinc", {31'h0, imem_rsp_valid}, 32'd1);
`ifdef IFQ_BYPASS_EN
      chk("t4_pop_coinc", {31'h0, inst_valid}, 32'd0);
`else
      chk("t4_pop_coinc", {31'h0, inst_valid}, 32'd1);
`endif
      n = pop_pc.size();
      tick();
      redir_valid = 1'b0;
      samp();
      chk("t4_empty", {31'h0, inst_valid}, 32'd0);
      wait_pops("t4_refill", n + 2);
      chk_pop("t4_first", n, 16'h0100);
      chk_pop("t4_second", n + 1, 16'h0101);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
